// File: rtl/wresp_chan_if.sv
// Write-response channel bundle: burst-completion reports in, bus write responses out.
// Handshake: a response transfers in any cycle where bvalid and bready are both high.
interface wresp_chan_if;
    logic        finish_swd;
    logic [31:0] finish_sid;
    logic        finish_serr;
    logic        wrsp_full;
    logic [2:0]  wrsp_cnt;
    logic        wrsp_ovf;
    logic        bvalid;
    logic        bready;
    logic [31:0] bid;
    logic        bcomp;

    modport slave (
        input  finish_swd, finish_sid, finish_serr, bready,
        output wrsp_full, wrsp_cnt, wrsp_ovf, bvalid, bid, bcomp
    );

    modport master (
        output finish_swd, finish_sid, finish_serr, bready,
        input  wrsp_full, wrsp_cnt, wrsp_ovf, bvalid, bid, bcomp
    );
endinterface

// File: rtl/wresp_chan_slv.sv
// Slave write response manager: 4-entry completion FIFO feeding a registered
// bvalid/bid/bcomp response stage.
module wresp_chan_slv #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    wresp_chan_if.slave bus,
    output logic [1:0]  state_dbg
);
    typedef enum logic [1:0] {
        RIDLE = 2'b00,
        RRESP = 2'b01,
        RDEFO = 2'b11
    } state_t;

    localparam logic [2:0] FULL_CNT = 3'(DEPTH);

    state_t      state, state_nxt;
    logic [32:0] mem [4];
    logic [1:0]  wptr, rptr;
    logic [2:0]  count;
    logic        full, push, load, ovf;
    logic [31:0] bid_q;
    logic        bcomp_q;

    assign full = (count == FULL_CNT);
    assign push = bus.finish_swd && !full;

    // Load pulls the head into the response stage; only legal states ever load.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            RIDLE: begin
                if (count != 3'd0) begin
                    load      = 1'b1;
                    state_nxt = RRESP;
                end
            end
            RRESP: begin
                if (bus.bready) begin
                    if (count != 3'd0) load = 1'b1;
                    else               state_nxt = RIDLE;
                end
            end
            RDEFO:   state_nxt = RDEFO;
            default: state_nxt = RDEFO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RIDLE;
        else        state <= state_nxt;
    end

    // Storage needs no reset: entries are only read once count says they are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {bus.finish_serr, bus.finish_sid};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= 2'd0;
            rptr    <= 2'd0;
            count   <= 3'd0;
            ovf     <= 1'b0;
            bid_q   <= 32'd0;
            bcomp_q <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 2'd1;
            if (load) begin
                rptr    <= rptr + 2'd1;
                bid_q   <= mem[rptr][31:0];
                bcomp_q <= ~mem[rptr][32];
            end
            case ({push, load})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (bus.finish_swd && full) ovf <= 1'b1;
        end
    end

    assign bus.bvalid    = (state == RRESP);
    assign bus.bid       = bid_q;
    assign bus.bcomp     = bcomp_q;
    assign bus.wrsp_full = full;
    assign bus.wrsp_cnt  = count;
    assign bus.wrsp_ovf  = ovf;
    assign state_dbg     = state;
endmodule

// File: tb/tb_wresp_chan_slv.sv
// Self-checking bench for wresp_chan_slv against a queue-based response model.
module tb_wresp_chan_slv;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] state_dbg;
    int         n_checks = 0;
    int         n_fail = 0;

    wresp_chan_if bus ();

    wresp_chan_slv #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // Reference model: pending completions plus one response slot.
    logic [32:0] exp_q[$];
    logic        m_ov = 1'b0;
    logic [31:0] m_id = 32'd0;
    logic        m_comp = 1'b0;
    logic        m_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_ov   = 1'b0;
            m_id   = 32'd0;
            m_comp = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            int          cnt0;
            logic [32:0] head;
            cnt0 = exp_q.size();
            if (cnt0 > 0 && (!m_ov || bus.bready)) begin
                head   = exp_q.pop_front();
                m_id   = head[31:0];
                m_comp = ~head[32];
                m_ov   = 1'b1;
            end else if (m_ov && bus.bready) begin
                m_ov = 1'b0;
            end
            if (bus.finish_swd) begin
                if (cnt0 < 4) exp_q.push_back({bus.finish_serr, bus.finish_sid});
                else          m_ovf = 1'b1;
            end
        end
    end

    // {state, bvalid, bid, bcomp, cnt, full, ovf}
    function automatic logic [40:0] exp_vec();
        logic [2:0] c;
        c = 3'(exp_q.size());
        return {(m_ov ? 2'b01 : 2'b00), m_ov, m_id, m_comp, c, (c == 3'd4), m_ovf};
    endfunction

    function automatic logic [40:0] obs_vec();
        return {state_dbg, bus.bvalid, bus.bid, bus.bcomp, bus.wrsp_cnt, bus.wrsp_full, bus.wrsp_ovf};
    endfunction

    task automatic cyc(input logic swd, input logic [31:0] id, input logic err, input logic rdy);
        @(negedge clk);
        bus.finish_swd  = swd;
        bus.finish_sid  = id;
        bus.finish_serr = err;
        bus.bready      = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.finish_swd = 1'b0; bus.finish_sid = 32'd0; bus.finish_serr = 1'b0; bus.bready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (obs_vec() !== 41'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", obs_vec(), 41'd0);
        end
        rst_n = 1'b1;
        cyc(0, 0, 0, 0);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL after_reset: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_single();
        cyc(1, 32'h11, 0, 1);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 1);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_model k=%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
            if (k == 0) begin
                n_checks++;
                if ({bus.bvalid, bus.bid, bus.bcomp} !== {1'b1, 32'h11, 1'b1}) begin
                    n_fail++;
                    $display("FAIL single_resp: got v=%b id=%h c=%b want v=1 id=11 c=1", bus.bvalid, bus.bid, bus.bcomp);
                end
            end
            if (k == 1) begin
                n_checks++;
                if ({bus.bvalid, bus.wrsp_cnt} !== {1'b0, 3'd0}) begin
                    n_fail++;
                    $display("FAIL single_done: got v=%b cnt=%0d want v=0 cnt=0", bus.bvalid, bus.wrsp_cnt);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] want;
        for (int i = 1; i <= 5; i++) cyc(1, 32'(i), 0, 0);
        n_checks++;
        if ({bus.wrsp_full, bus.wrsp_cnt, bus.bvalid, bus.bid} !== {1'b1, 3'd4, 1'b1, 32'd1}) begin
            n_fail++;
            $display("FAIL bp_full: got full=%b cnt=%0d v=%b id=%h want full=1 cnt=4 v=1 id=1",
                     bus.wrsp_full, bus.wrsp_cnt, bus.bvalid, bus.bid);
        end
        cyc(1, 32'd6, 0, 0);
        n_checks++;
        if ({bus.wrsp_ovf, bus.wrsp_cnt, bus.bid} !== {1'b1, 3'd4, 32'd1}) begin
            n_fail++;
            $display("FAIL bp_ovf: got ovf=%b cnt=%0d id=%h want ovf=1 cnt=4 id=1", bus.wrsp_ovf, bus.wrsp_cnt, bus.bid);
        end
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 0, 1);
            want = 32'(k + 2);
            n_checks++;
            if (k < 4 && {bus.bvalid, bus.bid} !== {1'b1, want}) begin
                n_fail++;
                $display("FAIL bp_order k=%0d: got v=%b id=%h want v=1 id=%h", k, bus.bvalid, bus.bid, want);
            end else if (k >= 4 && bus.bvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_drain k=%0d: got v=%b want v=0", k, bus.bvalid);
            end
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL bp_model k=%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) cyc(1, 32'h31 + 32'(i), 0, 0);
        n_checks++;
        if ({bus.bvalid, bus.wrsp_cnt, bus.wrsp_ovf} !== {1'b1, 3'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL rmid_pre: got v=%b cnt=%0d ovf=%b want v=1 cnt=3 ovf=1", bus.bvalid, bus.wrsp_cnt, bus.wrsp_ovf);
        end
        bus.finish_swd = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.bvalid, bus.wrsp_cnt, bus.wrsp_ovf} !== {1'b0, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL rmid_async: got v=%b cnt=%0d ovf=%b want v=0 cnt=0 ovf=0", bus.bvalid, bus.wrsp_cnt, bus.wrsp_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 1);
            n_checks++;
            if (bus.bvalid !== 1'b0 || obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL rmid_stale k=%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_error();
        cyc(1, 32'hA, 1, 1);
        cyc(0, 0, 0, 1);
        n_checks++;
        if ({bus.bvalid, bus.bid, bus.bcomp} !== {1'b1, 32'hA, 1'b0}) begin
            n_fail++;
            $display("FAIL err_resp: got v=%b id=%h c=%b want v=1 id=a c=0", bus.bvalid, bus.bid, bus.bcomp);
        end
        cyc(0, 0, 0, 1);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL err_model: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_simul();
        logic [31:0] ids [4];
        ids[0] = 32'h21; ids[1] = 32'h22; ids[2] = 32'h23; ids[3] = 32'h24;
        for (int i = 0; i < 3; i++) cyc(1, ids[i], 0, 0);
        n_checks++;
        if ({state_dbg, bus.wrsp_cnt, bus.bid} !== {2'b01, 3'd2, ids[0]}) begin
            n_fail++;
            $display("FAIL simul_pre: got st=%b cnt=%0d id=%h want st=01 cnt=2 id=%h", state_dbg, bus.wrsp_cnt, bus.bid, ids[0]);
        end
        cyc(1, ids[3], 0, 1);
        n_checks++;
        if ({bus.wrsp_cnt, bus.bvalid, bus.bid} !== {3'd2, 1'b1, ids[1]}) begin
            n_fail++;
            $display("FAIL simul_cnt: got cnt=%0d v=%b id=%h want cnt=2 v=1 id=%h", bus.wrsp_cnt, bus.bvalid, bus.bid, ids[1]);
        end
        for (int k = 2; k < 4; k++) begin
            cyc(0, 0, 0, 1);
            n_checks++;
            if ({bus.bvalid, bus.bid} !== {1'b1, ids[k]}) begin
                n_fail++;
                $display("FAIL simul_order k=%0d: got v=%b id=%h want v=1 id=%h", k, bus.bvalid, bus.bid, ids[k]);
            end
        end
        cyc(0, 0, 0, 1);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL simul_end: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            cyc(1, 32'(i), 0, 1);
            cyc(0, 0, 0, 1);
            n_checks++;
            if ({bus.bvalid, bus.bid} !== {1'b1, 32'(i)}) begin
                n_fail++;
                $display("FAIL wrap_id i=%0d: got v=%b id=%h want v=1 id=%h", i, bus.bvalid, bus.bid, 32'(i));
            end
            cyc(0, 0, 0, 1);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL wrap_model i=%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom_range(0, 99) < 45), $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) < 55));
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                if (bad < 10) $display("FAIL random k=%0d: got %h want %h", k, obs_vec(), exp_vec());
                bad++;
            end
        end
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 0, 1);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_drain k=%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_reset_mid();
        test_error();
        test_simul();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
